// File: rtl/echo_timer_pkg.sv
// Shared definitions for the ultrasonic echo timer: FSM state encoding and
// default timing for a 100 MHz clock.
package echo_timer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  localparam int DEF_SIZE        = 32;
  localparam int DEF_TRIG_CYC    = 1000;
  localparam int DEF_TIMEOUT     = 3_800_000;
  localparam int DEF_HOLDOFF_CYC = 6_000_000;

endpackage

// File: rtl/echo_timer_if.sv
// Request/result bundle between the echo timer, the sensor pins and the
// calculation stage.
interface echo_timer_if
  import echo_timer_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
);

  logic            strt;
  logic            echo_in;
  logic            trig_out;
  logic            busy;
  logic [SIZE-1:0] echo_out;
  logic            echo_rdy;
  logic            echo_err;

  modport master (
    output strt, echo_in,
    input  trig_out, busy, echo_out, echo_rdy, echo_err
  );

  modport slave (
    input  strt, echo_in,
    output trig_out, busy, echo_out, echo_rdy, echo_err
  );

endinterface

// File: rtl/echo_timer_sync.sv
// Two-flop synchroniser for the raw echo pin, with single-cycle rise/fall
// strobes derived from the synchronised level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/echo_timer.sv
// Ultrasonic echo timer: fires the trigger pulse, times the synchronised echo
// high-time in clk cycles and enforces a dead time before the next request.
module echo_timer
  import echo_timer_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic         clk,
  input  logic         rst_n,
  echo_timer_if.slave  bus
);

  localparam logic [SIZE-1:0] TRIG_LAST    = SIZE'(TRIG_CYC - 1);
  localparam logic [SIZE-1:0] TIMEOUT_LAST = SIZE'(TIMEOUT - 1);
  localparam logic [SIZE-1:0] TIMEOUT_MAX  = SIZE'(TIMEOUT);
  localparam logic [SIZE-1:0] HOLD_LAST    = SIZE'(HOLDOFF_CYC - 1);
  localparam logic [SIZE-1:0] CNT_SAT      = '1;

  // The measurement counter must be able to hold TIMEOUT without wrapping.
  if ((SIZE < 63) && (longint'(TIMEOUT) >= (longint'(1) << SIZE))) begin : g_size_check
    $error("echo_timer: TIMEOUT does not fit in SIZE bits");
  end

  logic [2:0]      state;
  logic [SIZE-1:0] cnt;
  logic            trig_q;
  logic [SIZE-1:0] echo_q;
  logic            rdy_q;
  logic            err_q;
  logic            echo_level;
  logic            echo_rise;
  logic            echo_fall;

  echo_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.echo_in),
    .level    (echo_level),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  // One counter serves every timed state; it is cleared on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      trig_q <= 1'b0;
      echo_q <= '0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.strt) begin
            state  <= ST_TRIG;
            trig_q <= 1'b1;
            rdy_q  <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_TRIG: begin
          if (cnt == TRIG_LAST) begin
            state  <= ST_WAIT_RISE;
            trig_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (echo_rise) begin
            state <= ST_MEASURE;
            cnt   <= SIZE'(1);
          end else if (cnt == TIMEOUT_LAST) begin
            state <= ST_HOLDOFF;
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MEASURE: begin
          // A fall on the same cycle the limit is hit still yields a valid count.
          if (echo_fall) begin
            state  <= ST_HOLDOFF;
            echo_q <= cnt;
            rdy_q  <= 1'b1;
            cnt    <= '0;
          end else if (cnt >= TIMEOUT_MAX) begin
            state <= ST_HOLDOFF;
            err_q <= 1'b1;
            cnt   <= '0;
          end else if (echo_level && (cnt != CNT_SAT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          trig_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.trig_out = trig_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.echo_out = echo_q;
  assign bus.echo_rdy = rdy_q;
  assign bus.echo_err = err_q;

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer: expected measurement outcomes are queued
// when an echo is scheduled and matched against echo_rdy/echo_err events.
module tb_echo_timer;

  localparam int SIZE        = 32;
  localparam int TRIG_CYC    = 10;
  localparam int TIMEOUT     = 1000;
  localparam int HOLDOFF_CYC = 20;

  typedef struct {
    bit          isErr;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;
  exp_t expQ[$];
  exp_t popped;
  logic prevRdy;
  logic prevErr;
  int   n;

  echo_timer_if #(.SIZE(SIZE)) bus ();

  echo_timer #(
    .SIZE        (SIZE),
    .TRIG_CYC    (TRIG_CYC),
    .TIMEOUT     (TIMEOUT),
    .HOLDOFF_CYC (HOLDOFF_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pushExp(input bit isErr, input logic [31:0] val);
    exp_t e;
    e.isErr = isErr;
    e.val   = val;
    expQ.push_back(e);
  endtask

  // Pulse strt from IDLE and time the trigger; returns on the first negedge with trig_out low.
  task automatic startMeasure(input int extraAt);
    int k;
    @(negedge clk);
    bus.strt = 1'b1;
    @(negedge clk);
    bus.strt = 1'b0;
    checkOutput("start_trig", bus.trig_out, 1);
    checkOutput("start_busy", bus.busy, 1);
    checkOutput("start_rdy_clear", bus.echo_rdy, 0);
    k = 0;
    while (bus.trig_out && k < 100) begin
      bus.strt = (k == extraAt);
      k++;
      @(negedge clk);
    end
    bus.strt = 1'b0;
    checkOutput("trig_len", k, TRIG_CYC);
  endtask

  task automatic applyStimulus(input int delay, input int width, input int strtAt);
    repeat (delay) @(negedge clk);
    for (int i = 0; i < width; i++) begin
      bus.echo_in = 1'b1;
      bus.strt    = (i == strtAt);
      @(negedge clk);
    end
    bus.echo_in = 1'b0;
    bus.strt    = 1'b0;
  endtask

  // Wait for the result (or error) event, then time the dead time until busy drops.
  task automatic finishMeasure(input bit expectErr, input int strtAt, output int latency);
    int k;
    int m;
    k = 0;
    while (!(expectErr ? bus.echo_err : bus.echo_rdy) && k < 3000) begin
      k++;
      @(negedge clk);
    end
    latency = k;
    checkOutput(expectErr ? "err_seen" : "rdy_seen", expectErr ? bus.echo_err : bus.echo_rdy, 1);
    m = 0;
    while (bus.busy && m < 100) begin
      bus.strt = (m == strtAt);
      m++;
      @(negedge clk);
    end
    bus.strt = 1'b0;
    checkOutput("holdoff_len", m, HOLDOFF_CYC);
  endtask

  // Scoreboard monitor: every result or error event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.echo_err || (bus.echo_rdy && !prevRdy)) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_event", {bus.echo_err, bus.echo_rdy}, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("sb_kind_err", bus.echo_err, popped.isErr);
          checkOutput("sb_echo_out", bus.echo_out, popped.val);
          if (popped.isErr) checkOutput("sb_rdy_on_err", bus.echo_rdy, 0);
        end
      end
      if (bus.echo_err) checkOutput("err_one_cycle", prevErr, 0);
    end
    prevRdy <= bus.echo_rdy;
    prevErr <= bus.echo_err;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    bus.strt    = 1'b0;
    bus.echo_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_trig", bus.trig_out, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_echo_out", bus.echo_out, 0);
    checkOutput("reset_rdy", bus.echo_rdy, 0);
    checkOutput("reset_err", bus.echo_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: 250-cycle echo");
    startMeasure(-1);
    pushExp(1'b0, 250);
    applyStimulus(40, 250, -1);
    finishMeasure(1'b0, -1, n);
    checkOutput("t1_idle_busy", bus.busy, 0);

    $display("[TB] test 2: echo never rises");
    startMeasure(-1);
    pushExp(1'b1, 250);
    finishMeasure(1'b1, -1, n);
    checkOutput("t2_err_latency", n, TIMEOUT);
    checkOutput("t2_rdy", bus.echo_rdy, 0);
    checkOutput("t2_echo_out_held", bus.echo_out, 250);

    $display("[TB] test 3: echo high on entry, then 100-cycle pulse");
    bus.echo_in = 1'b1;
    startMeasure(-1);
    repeat (5) @(negedge clk);
    bus.echo_in = 1'b0;
    pushExp(1'b0, 100);
    applyStimulus(10, 100, -1);
    finishMeasure(1'b0, -1, n);

    $display("[TB] test 4: echo too long");
    startMeasure(-1);
    pushExp(1'b1, 100);
    repeat (40) @(negedge clk);
    bus.echo_in = 1'b1;
    finishMeasure(1'b1, -1, n);
    checkOutput("t4_idle_busy", bus.busy, 0);
    repeat (450) @(negedge clk);
    bus.echo_in = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t4_rdy", bus.echo_rdy, 0);
    checkOutput("t4_echo_out_held", bus.echo_out, 100);

    $display("[TB] test 5: strt while busy is ignored");
    startMeasure(3);
    pushExp(1'b0, 60);
    applyStimulus(20, 60, 30);
    finishMeasure(1'b0, 5, n);
    repeat (3) @(negedge clk);
    checkOutput("t5_no_queue", bus.busy, 0);
    checkOutput("t5_rdy_held", bus.echo_rdy, 1);
    startMeasure(-1);
    pushExp(1'b0, 77);
    applyStimulus(10, 77, -1);
    finishMeasure(1'b0, -1, n);

    $display("[TB] test 6: reset mid-measurement");
    startMeasure(-1);
    repeat (20) @(negedge clk);
    bus.echo_in = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("t6_busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_trig", bus.trig_out, 0);
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_echo_out", bus.echo_out, 0);
    checkOutput("t6_rdy", bus.echo_rdy, 0);
    checkOutput("t6_err", bus.echo_err, 0);
    @(negedge clk);
    bus.echo_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    startMeasure(-1);
    pushExp(1'b0, 33);
    applyStimulus(15, 33, -1);
    finishMeasure(1'b0, -1, n);

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
